display_sequencer: RTL and testbench

//  Top-level screen-mode controller for the VGA output path. It sequences TITLE -> COUNTDOWN -> PLAY -> OVER,

---
 rtl/display_sequencer.sv | 171 +++++++++++++++++
 tb/tb_display_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_sequencer.sv
// display_sequencer: screen-mode FSM (TITLE/COUNTDOWN/PLAY/OVER) and final pixel-colour mux
// aligned to the 1-cycle image-ROM latency; pixel_color is valid two cycles after (x,y).
module display_sequencer #(
    parameter int                        SCREEN_WIDTH     = 640,
    parameter int                        SCREEN_HEIGHT    = 480,
    parameter int                        BITS_PER_COLOR   = 12,
    parameter logic [BITS_PER_COLOR-1:0] BG_COLOR         = '0,
    parameter logic [7:0]                COUNTDOWN_FRAMES = 8'd180,
    parameter logic [7:0]                OVER_FRAMES      = 8'd120,
    parameter logic [7:0]                BLINK_FRAMES     = 8'd15
) (
    input  logic                      i_clk,
    input  logic                      i_resetn,
    input  logic [9:0]                i_x,
    input  logic [8:0]                i_y,
    input  logic                      i_frame_start,
    input  logic                      i_start_btn,
    input  logic                      i_game_over,
    input  logic                      i_inside_title,
    input  logic [BITS_PER_COLOR-1:0] i_title_data,
    input  logic                      i_game_valid,
    input  logic [BITS_PER_COLOR-1:0] i_game_data,
    output logic [1:0]                o_state,
    output logic                      o_title_en,
    output logic                      o_game_en,
    output logic [BITS_PER_COLOR-1:0] o_pixel_color
);
    localparam logic [1:0] S_TITLE = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;
    localparam logic [9:0] W_MAX   = 10'(SCREEN_WIDTH);
    localparam logic [8:0] H_MAX   = 9'(SCREEN_HEIGHT);
    localparam int         CW      = BITS_PER_COLOR / 3;

    logic [1:0]                r_state;
    logic [7:0]                r_frame_cnt;
    logic [7:0]                r_blink_cnt;
    logic                      r_blink;
    logic                      r_start_pend;
    logic                      r_over_pend;
    logic                      r_btn_q;
    logic                      r_title_en;
    logic                      r_game_en;
    logic                      r_inside_d;
    logic                      r_game_valid_d;
    logic                      r_active_d;
    logic [1:0]                r_state_d;
    logic                      r_title_en_d;
    logic [BITS_PER_COLOR-1:0] r_pixel;

    logic                      w_edge;
    logic [7:0]                w_cnt_inc;
    logic [7:0]                w_blink_inc;
    logic [1:0]                w_state_n;
    logic [7:0]                w_cnt_n;
    logic [7:0]                w_blink_cnt_n;
    logic                      w_blink_n;
    logic                      w_start_pend_n;
    logic                      w_over_pend_n;
    logic                      w_title_en_n;
    logic                      w_game_en_n;
    logic                      w_active;
    logic [BITS_PER_COLOR-1:0] w_half;
    logic [BITS_PER_COLOR-1:0] w_pixel_n;

    assign w_edge      = i_start_btn & ~r_btn_q;
    assign w_cnt_inc   = r_frame_cnt + 8'd1;
    assign w_blink_inc = r_blink_cnt + 8'd1;
    assign w_active    = (i_x < W_MAX) && (i_y < H_MAX);

    // Mode changes are confined to frame_start so a frame is never drawn in two modes.
    always_comb begin
        w_state_n      = r_state;
        w_cnt_n        = r_frame_cnt;
        w_blink_cnt_n  = r_blink_cnt;
        w_blink_n      = r_blink;
        w_start_pend_n = r_start_pend;
        w_over_pend_n  = r_over_pend;
        case (r_state)
            S_TITLE: begin
                if (i_frame_start && (r_start_pend || w_edge)) begin
                    w_state_n      = S_COUNT;
                    w_cnt_n        = 8'd0;
                    w_blink_cnt_n  = 8'd0;
                    w_blink_n      = 1'b1;
                    w_start_pend_n = 1'b0;
                end else if (w_edge) begin
                    w_start_pend_n = 1'b1;
                end
            end
            S_COUNT: begin
                if (i_frame_start) begin
                    w_state_n     = (w_cnt_inc == COUNTDOWN_FRAMES) ? S_PLAY : S_COUNT;
                    w_cnt_n       = (w_cnt_inc == COUNTDOWN_FRAMES) ? 8'd0 : w_cnt_inc;
                    w_blink_n     = (w_blink_inc == BLINK_FRAMES) ? ~r_blink : r_blink;
                    w_blink_cnt_n = (w_blink_inc == BLINK_FRAMES) ? 8'd0 : w_blink_inc;
                end
            end
            S_PLAY: begin
                if (i_frame_start && (r_over_pend || i_game_over)) begin
                    w_state_n     = S_OVER;
                    w_cnt_n       = 8'd0;
                    w_over_pend_n = 1'b0;
                end else if (i_game_over) begin
                    w_over_pend_n = 1'b1;
                end
            end
            default: begin
                if (i_frame_start) begin
                    w_state_n = (w_cnt_inc == OVER_FRAMES) ? S_TITLE : S_OVER;
                    w_cnt_n   = (w_cnt_inc == OVER_FRAMES) ? 8'd0 : w_cnt_inc;
                end
            end
        endcase
        w_title_en_n = (w_state_n == S_TITLE) || ((w_state_n == S_COUNT) && w_blink_n);
        w_game_en_n  = (w_state_n == S_PLAY);
    end

    // OVER dims the game layer: each channel halved independently.
    always_comb begin
        w_half = '0;
        for (int c = 0; c < 3; c++)
            w_half[c*CW +: CW] = i_game_data[c*CW +: CW] >> 1;
        w_pixel_n = !r_active_d                ? '0 :
                    (r_state_d == S_PLAY)      ? (r_game_valid_d ? i_game_data : BG_COLOR) :
                    (r_state_d == S_OVER)      ? (r_game_valid_d ? w_half : BG_COLOR) :
                    (r_title_en_d && r_inside_d) ? i_title_data : BG_COLOR;
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state        <= S_TITLE;
            r_frame_cnt    <= 8'd0;
            r_blink_cnt    <= 8'd0;
            r_blink        <= 1'b1;
            r_start_pend   <= 1'b0;
            r_over_pend    <= 1'b0;
            r_btn_q        <= 1'b1;
            r_title_en     <= 1'b1;
            r_game_en      <= 1'b0;
            r_inside_d     <= 1'b0;
            r_game_valid_d <= 1'b0;
            r_active_d     <= 1'b0;
            r_state_d      <= S_TITLE;
            r_title_en_d   <= 1'b0;
            r_pixel        <= '0;
        end else begin
            r_state        <= w_state_n;
            r_frame_cnt    <= w_cnt_n;
            r_blink_cnt    <= w_blink_cnt_n;
            r_blink        <= w_blink_n;
            r_start_pend   <= w_start_pend_n;
            r_over_pend    <= w_over_pend_n;
            r_btn_q        <= i_start_btn;
            r_title_en     <= w_title_en_n;
            r_game_en      <= w_game_en_n;
            r_inside_d     <= i_inside_title;
            r_game_valid_d <= i_game_valid;
            r_active_d     <= w_active;
            r_state_d      <= r_state;
            r_title_en_d   <= r_title_en;
            r_pixel        <= w_pixel_n;
        end
    end

    assign o_state       = r_state;
    assign o_title_en    = r_title_en;
    assign o_game_en     = r_game_en;
    assign o_pixel_color = r_pixel;
endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: directed + randomized bench against a frame-level behavioural model.
module tb_display_sequencer;
    localparam int CD = 4;
    localparam int OV = 3;
    localparam int BL = 1;
    localparam logic [11:0] BG = 12'h000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn = 1'b0, frame_start = 1'b0, start_btn = 1'b0, game_over = 1'b0;
    logic        inside_title = 1'b0, game_valid = 1'b0;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic [11:0] title_data = '0, game_data = '0;
    logic [1:0]  state;
    logic        title_en, game_en;
    logic [11:0] pixel_color;

    display_sequencer #(
        .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .BITS_PER_COLOR(12), .BG_COLOR(BG),
        .COUNTDOWN_FRAMES(8'(CD)), .OVER_FRAMES(8'(OV)), .BLINK_FRAMES(8'(BL))
    ) dut (
        .i_clk(clk), .i_resetn(resetn), .i_x(x), .i_y(y), .i_frame_start(frame_start),
        .i_start_btn(start_btn), .i_game_over(game_over), .i_inside_title(inside_title),
        .i_title_data(title_data), .i_game_valid(game_valid), .i_game_data(game_data),
        .o_state(state), .o_title_en(title_en), .o_game_en(game_en), .o_pixel_color(pixel_color)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    int          m_mode, m_frames;
    bit          m_spend, m_opend, m_btnq, m_te, m_ge;
    logic [11:0] m_pix;
    bit          p_act, p_in, p_gv, p_te;
    int          p_mode;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
        end
    endtask

    // Title blinks: after k countdown frames it has toggled floor(k/BL) times.
    function automatic bit te_of(input int mode, input int fr);
        return mode == 0 || (mode == 1 && ((fr / BL) % 2 == 0));
    endfunction

    task automatic model_edge();
        bit          e;
        logic [11:0] h;
        if (!resetn) begin
            m_mode = 0; m_frames = 0; m_spend = 0; m_opend = 0; m_btnq = 1; m_pix = '0;
            p_act = 0; p_in = 0; p_gv = 0; p_te = 0; p_mode = 0;
        end else begin
            e = start_btn && !m_btnq;
            m_btnq = start_btn;
            h = {1'b0, game_data[11:9], 1'b0, game_data[7:5], 1'b0, game_data[3:1]};
            if (!p_act)           m_pix = '0;
            else if (p_mode == 2) m_pix = p_gv ? game_data : BG;
            else if (p_mode == 3) m_pix = p_gv ? h : BG;
            else                  m_pix = (p_te && p_in) ? title_data : BG;
            p_act  = (int'(x) < 640) && (int'(y) < 480);
            p_in   = inside_title;
            p_gv   = game_valid;
            p_mode = m_mode;
            p_te   = te_of(m_mode, m_frames);
            case (m_mode)
                0: if (frame_start && (m_spend || e)) begin m_mode = 1; m_frames = 0; m_spend = 0; end
                   else if (e) m_spend = 1;
                1: if (frame_start) begin
                       m_frames++;
                       if (m_frames == CD) begin m_mode = 2; m_frames = 0; end
                   end
                2: if (frame_start && (m_opend || game_over)) begin m_mode = 3; m_frames = 0; m_opend = 0; end
                   else if (game_over) m_opend = 1;
                default: if (frame_start) begin
                       m_frames++;
                       if (m_frames == OV) begin m_mode = 0; m_frames = 0; end
                   end
            endcase
        end
        m_te = te_of(m_mode, m_frames);
        m_ge = (m_mode == 2);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", 32'(state), 32'(m_mode));
            chk("title_en", 32'(title_en), 32'(m_te));
            chk("game_en", 32'(game_en), 32'(m_ge));
            chk("pixel_color", 32'(pixel_color), 32'(m_pix));
        end
    end

    initial begin
        resetn = 1'b0; start_btn = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst state", 32'(state), 0);
        chk("rst title_en", 32'(title_en), 1);
        chk("rst game_en", 32'(game_en), 0);
        chk("rst pixel", 32'(pixel_color), 0);
        chk("model rst state", 32'(m_mode), 0);
        resetn = 1'b1;
        frame();
        chk("held btn ignored", 32'(state), 0);

        x = 10'd300; y = 9'd100; inside_title = 1'b1;
        tick();
        x = 10'd700; title_data = 12'hF00;
        tick();
        chk("title pixel", 32'(pixel_color), 32'h0F00);
        chk("model title pixel", 32'(m_pix), 32'h0F00);
        title_data = 12'h0F0;
        tick();
        chk("offscreen pixel", 32'(pixel_color), 0);
        x = '0; y = '0; inside_title = 1'b0;

        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick(); tick(); tick();
        chk("pending start", 32'(state), 0);
        frame();
        chk("enter countdown", 32'(state), 1);
        chk("blink frame0", 32'(title_en), 1);
        for (int k = 1; k <= 3; k++) begin
            frame();
            chk("blink", 32'(title_en), 32'(k % 2 == 0));
            chk("countdown hold", 32'(state), 1);
        end
        frame();
        chk("enter play", 32'(state), 2);
        chk("play game_en", 32'(game_en), 1);
        chk("model play", 32'(m_mode), 2);

        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        tick();
        chk("over pending", 32'(state), 2);
        frame();
        chk("enter over", 32'(state), 3);
        x = 10'd10; y = 9'd10; game_valid = 1'b1;
        tick();
        game_valid = 1'b0; game_data = 12'hF84;
        tick();
        chk("dim pixel", 32'(pixel_color), 32'h0742);
        chk("model dim pixel", 32'(m_pix), 32'h0742);
        for (int k = 1; k <= OV; k++) begin
            frame();
            chk("over count", 32'(state), (k < OV) ? 3 : 0);
        end

        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        frame();
        chk("game_over in title", 32'(state), 0);

        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        frame();
        chk("edge with frame_start", 32'(state), 1);

        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        resetn = 1'b0;
        tick();
        chk("mid-cd reset state", 32'(state), 0);
        chk("mid-cd reset pixel", 32'(pixel_color), 0);
        resetn = 1'b1;
        frame();
        chk("no spurious start", 32'(state), 0);

        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        frame();
        chk("pend cleared by reset", 32'(state), 0);
        chk("model pend cleared", 32'(m_mode), 0);

        for (int i = 0; i < 5000; i++) begin
            resetn       = ($urandom_range(0, 799) != 0);
            frame_start  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
            game_over    = ($urandom_range(0, 24) == 0);
            x            = 10'($urandom_range(0, 720));
            y            = 9'($urandom_range(0, 511));
            inside_title = 1'($urandom);
            game_valid   = 1'($urandom);
            title_data   = 12'($urandom);
            game_data    = 12'($urandom);
            tick();
        end
        frame_start = 1'b0; game_over = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
